// File: rtl/timer_pkg.sv
// ============================================================================
// Module      : timer_pkg
// Description : Shared state encoding and parameter defaults for timer_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

    localparam int unsigned C_TICK_DIV_DEFAULT      = 50_000_000;
    localparam int unsigned C_RECONF_CYCLES_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_EXPIRED = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running 0..TICK_DIV-1 counter; tick flags the last count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = C_TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned    C_W    = $clog2(TICK_DIV);
    localparam logic [C_W-1:0] C_LAST = C_W'(TICK_DIV - 1);
    localparam logic [C_W-1:0] C_ONE  = C_W'(1);

    logic [C_W-1:0] r_count;

    // Wrap by compare-and-clear so non-power-of-two dividers work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            if (r_count == C_LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + C_ONE;
            end
        end
    end

    assign tick = (r_count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/timer_ctrl.sv
// ============================================================================
// Module      : timer_ctrl
// Description : Countdown controller driving reconf/borrow of a digit chain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV      = C_TICK_DIV_DEFAULT,
    parameter int unsigned RECONF_CYCLES = C_RECONF_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic start,
    input  logic pause,
    input  logic noborrow_in,
    output logic reconf,
    output logic borrow_req,
    output logic running,
    output logic expired
);

    localparam logic [3:0] C_RECONF_LAST = 4'(RECONF_CYCLES - 1);

    logic       r_nb_meta;
    logic       r_nb_s;
    state_t     r_state;
    logic [3:0] r_reconf_cnt;
    logic       w_tick;
    logic       w_clr;
    logic       w_en;

    // Synchronizer idles at "chain empty" so an early start cannot borrow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nb_meta <= 1'b1;
            r_nb_s    <= 1'b1;
        end else begin
            r_nb_meta <= noborrow_in;
            r_nb_s    <= r_nb_meta;
        end
    end

    // A pause landing on the terminal count holds it, so the tick is not lost.
    always_comb begin
        w_clr = 1'b0;
        w_en  = 1'b0;
        case (r_state)
            ST_IDLE: w_clr = load | start;
            ST_LOAD: w_clr = 1'b1;
            ST_RUN: begin
                w_clr = load;
                w_en  = !load && !r_nb_s && !(pause && w_tick);
            end
            default: w_clr = load;
        endcase
    end

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .en   (w_en),
        .tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_reconf_cnt <= '0;
            reconf       <= 1'b0;
            borrow_req   <= 1'b0;
            running      <= 1'b0;
            expired      <= 1'b0;
        end else begin
            borrow_req <= 1'b0;
            if (load) begin
                r_state      <= ST_LOAD;
                r_reconf_cnt <= '0;
                reconf       <= 1'b1;
                running      <= 1'b0;
                expired      <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && r_nb_s) begin
                            r_state <= ST_EXPIRED;
                            expired <= 1'b1;
                        end else if (start) begin
                            r_state <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        if (r_reconf_cnt == C_RECONF_LAST) begin
                            r_state <= ST_IDLE;
                            reconf  <= 1'b0;
                        end else begin
                            r_reconf_cnt <= r_reconf_cnt + 4'd1;
                        end
                    end
                    ST_RUN: begin
                        if (r_nb_s) begin
                            r_state <= ST_EXPIRED;
                            running <= 1'b0;
                            expired <= 1'b1;
                        end else if (pause) begin
                            r_state <= ST_PAUSE;
                            running <= 1'b0;
                        end else begin
                            borrow_req <= w_tick;
                        end
                    end
                    ST_PAUSE: begin
                        if (start && !pause) begin
                            r_state <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    ST_EXPIRED: begin
                        r_state <= ST_EXPIRED;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        reconf  <= 1'b0;
                        running <= 1'b0;
                        expired <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000: clk cycles per countdown tick (1 Hz at 50 MHz); legal range 2..2^26.
REQ-002 Parameter RECONF_CYCLES, default 2: cycles reconf is held high during a load; legal range 1..15.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 load  in  1  request to reload the digit chain from its count_default inputs.
REQ-006 start  in  1  begin or resume countdown.
REQ-007 pause  in  1  suspend countdown.
REQ-008 noborrow_in  in  1  from noborrow_dn of the lowest digit; high = chain reads all zeros; asynchronous to clk.
REQ-009 reconf  out  1  drives the reconf input of every digit in the chain.
REQ-010 borrow_req  out  1  drives borrow_dn of the lowest digit; a one-cycle pulse requests one decrement.
REQ-011 running  out  1  high while in RUN.
REQ-012 expired  out  1  level; high in EXPIRED.

Function
REQ-013 noborrow_in SHALL pass through a 2-flop synchronizer; nb_s is the synchronized value; all decisions use nb_s only.
REQ-014 FSM states SHALL be IDLE, LOAD, RUN, PAUSE, EXPIRED.
REQ-015 Input priority when sampled in the same cycle SHALL be load > pause > start.
REQ-016 load in any state SHALL go to LOAD, clear the prescaler and clear expired.
REQ-017 LOAD SHALL hold reconf high for exactly RECONF_CYCLES cycles and then go to IDLE.
REQ-018 load asserted while already in LOAD SHALL restart the RECONF_CYCLES count.
REQ-019 IDLE + start: nb_s=1 -> EXPIRED with no borrow_req; nb_s=0 -> RUN with the prescaler cleared.
REQ-020 In RUN, the prescaler SHALL count 0..TICK_DIV-1 and wrap.
REQ-021 In RUN, when the prescaler reaches TICK_DIV-1 and nb_s=0, borrow_req SHALL be high for exactly that one cycle.
REQ-022 The first borrow_req after entering RUN from IDLE SHALL occur TICK_DIV cycles after the start edge.
REQ-023 In RUN, nb_s=1 SHALL go to EXPIRED on the next edge, with no borrow_req that cycle, even if a tick coincides.
REQ-024 RUN + pause -> PAUSE; the prescaler value SHALL be frozen, not cleared.
REQ-025 PAUSE + start -> RUN, continuing from the frozen prescaler value.
REQ-026 pause in IDLE, PAUSE or EXPIRED SHALL be ignored.
REQ-027 start in RUN or EXPIRED SHALL be ignored.
REQ-028 EXPIRED SHALL be left only by load or rst.
REQ-029 borrow_req SHALL never be high in any state other than RUN.
REQ-030 reconf SHALL be high only in LOAD.
REQ-031 At most one borrow_req pulse SHALL occur per TICK_DIV cycles.
REQ-032 The prescaler width SHALL be $clog2(TICK_DIV); wrap SHALL be by compare-and-clear, not by overflow.

Reset
REQ-033 rst high SHALL immediately force: state=IDLE, prescaler=0, synchronizer flops=1, reconf=0, borrow_req=0, running=0, expired=0.
REQ-034 rst asserted mid-RUN or mid-LOAD SHALL abort with no further pulse on borrow_req or reconf.
REQ-035 After rst deasserts, the block SHALL stay in IDLE until load or start.
REQ-036 The synchronizer resets to 1 so that a start in the first 2 cycles after reset goes to EXPIRED rather than issuing a borrow.

Structure
REQ-037 A package timer_pkg SHALL hold the state enum and the default values of TICK_DIV and RECONF_CYCLES.
REQ-038 The prescaler SHALL be a sub-module tick_prescaler with ports clk, rst, clr, en, tick.
REQ-039 The synchronizer and FSM SHALL stay in timer_ctrl.

Verification (TICK_DIV=4, RECONF_CYCLES=2, model chain = two digitClock instances preset to 0x02)
REQ-040 rst, then load for 1 cycle -> reconf high exactly 2 cycles, then IDLE; expired=0.
REQ-041 start with chain=02 -> borrow_req at cycles 4 and 8 after start; chain reads 00; nb_s rises; expired=1 within 3 cycles; no third borrow_req.
REQ-042 start, pause at cycle 2, hold 10 cycles, start -> next borrow_req 2 cycles after resume; no borrow_req while paused.
REQ-043 load, start and pause in the same cycle during RUN -> LOAD taken; reconf for 2 cycles; running=0; prescaler cleared.
REQ-044 Chain preset 00, load, then start -> EXPIRED; zero borrow_req pulses.
REQ-045 rst asserted in the middle of a RUN tick -> all outputs 0 asynchronously, before the next clk edge; no borrow_req after rst is released.
